// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine: shift-add multiply, restoring divide, sign fix-up, HI/LO write strobes.
// Optional build macro MULDIV_EARLY_OUT_EN: zero-operand multiply and |a|<|b| divide skip straight to DONE.
module muldiv_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             write_hi,
   output logic             write_lo,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic             r_is_div, r_sa, r_sb;
   logic [WIDTH-1:0] r_hi, r_lo, r_mc;

   logic             w_sa, w_sb, w_div0, w_early_mul, w_early_div, w_bypass;
   logic [WIDTH-1:0] w_mag_a, w_mag_b;
   logic [WIDTH:0]   w_sum;
   logic             w_ge;
   logic [WIDTH-1:0] w_sub;
   logic [WIDTH-1:0] w_step_hi, w_step_lo, w_fix_hi, w_fix_lo;
   logic [2*WIDTH-1:0] w_prod, w_prod_s;

   // Operand conditioning: op[0]==0 selects the signed variant of either operation.
   assign w_sa    = ~op[0] & a[WIDTH-1];
   assign w_sb    = ~op[0] & b[WIDTH-1];
   assign w_mag_a = w_sa ? -a : a;
   assign w_mag_b = w_sb ? -b : b;
   assign w_div0  = op[1] & (b == '0);

`ifdef MULDIV_EARLY_OUT_EN
   assign w_early_mul = ~op[1] & ((a == '0) | (b == '0));
   assign w_early_div = op[1] & (b != '0) & (w_mag_a < w_mag_b);
`else
   assign w_early_mul = 1'b0;
   assign w_early_div = 1'b0;
`endif

   assign w_bypass = w_div0 | w_early_mul | w_early_div;

   // One iteration: multiply shifts {hi,lo} right after adding; divide shifts left with a trial subtract.
   assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : '0);
   assign w_ge  = {r_hi, r_lo[WIDTH-1]} >= {1'b0, r_mc};
   assign w_sub = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} - r_mc;

   always_comb begin
      w_step_hi = w_sum[WIDTH:1];
      w_step_lo = {w_sum[0], r_lo[WIDTH-1:1]};
      if (r_is_div) begin
         w_step_hi = w_ge ? w_sub : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
         w_step_lo = {r_lo[WIDTH-2:0], w_ge};
      end
   end

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = (r_sa ^ r_sb) ? -w_prod : w_prod;

   always_comb begin
      w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod_s[WIDTH-1:0];
      if (r_is_div) begin
         w_fix_hi = r_sa ? -r_hi : r_hi;
         w_fix_lo = (r_sa ^ r_sb) ? -r_lo : r_lo;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      busy     = 1'b0;
      done     = 1'b0;
      write_hi = 1'b0;
      write_lo = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_next = w_bypass ? S_DONE : S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (r_cnt == LAST) w_next = S_FIX;
         end
         S_FIX: begin
            busy   = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            write_hi = 1'b1;
            write_lo = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_mc     <= '0;
         hi_o     <= '0;
         lo_o     <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_cnt    <= '0;
               r_is_div <= op[1];
               r_sa     <= w_sa;
               r_sb     <= w_sb;
               r_hi     <= '0;
               r_mc     <= op[1] ? w_mag_b : w_mag_a;
               r_lo     <= op[1] ? w_mag_a : w_mag_b;
               if (w_div0) begin
                  hi_o <= a;
                  lo_o <= '1;
               end else if (w_early_mul) begin
                  hi_o <= '0;
                  lo_o <= '0;
               end else if (w_early_div) begin
                  hi_o <= a;
                  lo_o <= '0;
               end
            end
            S_RUN: begin
               r_hi  <= w_step_hi;
               r_lo  <= w_step_lo;
               r_cnt <= r_cnt + 1'b1;
            end
            S_FIX: begin
               hi_o <= w_fix_hi;
               lo_o <= w_fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule
